// File: rtl/cache_arb_pkg.sv
// Shared types and constants for the cache fill arbiter.
// Holds the FSM state enum, default parameters and the word stride.
package cache_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_FILL  = 2'd2
    } arb_state_e;

    localparam int DEF_NUM_PORTS       = 2;
    localparam int DEF_WORDS_PER_BLOCK = 8;
    localparam int DEF_ADDR_W          = 16;
    localparam int DEF_DATA_W          = 16;

    // Byte distance between consecutive 16-bit words.
    localparam int WORD_STRIDE = 2;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational grant picker: request vector (+ pointer) -> one-hot grant.
// Ports: req_i requests, ptr_i last granted index (round-robin build only),
//   gnt_o one-hot grant.
// Macro CACHE_ARB_ROUND_ROBIN_EN selects round-robin; otherwise lowest
// index wins and there is no pointer input.
module rr_arbiter #(
    parameter int N  = 2,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
`ifdef CACHE_ARB_ROUND_ROBIN_EN
    input  logic [PW-1:0] ptr_i,
`endif
    output logic [N-1:0]  gnt_o
);

    logic found;

    always_comb begin
        gnt_o = '0;
        found = 1'b0;
`ifdef CACHE_ARB_ROUND_ROBIN_EN
        // Scan from the port after the pointer, wrapping.
        for (int k = 1; k <= N; k++) begin
            for (int j = 0; j < N; j++) begin
                if (!found && req_i[j] &&
                    (((int'(ptr_i) + k) % N) == j)) begin
                    gnt_o[j] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
`else
        for (int j = 0; j < N; j++) begin
            if (!found && req_i[j]) begin
                gnt_o[j] = 1'b1;
                found    = 1'b1;
            end
        end
`endif
    end

endmodule

// File: rtl/cache_arbiter_n.sv
// Arbitrates cache block fills from N ports and write-throughs onto one
// pipelined memory port (one request/cycle, fixed read latency).
// Ports: clk, rst (async high); miss_req/miss_addr per port; wr_req/
//   wr_addr/wr_data -> wr_ack; fill_data/fill_addr with one-hot
//   fill_data_we/fill_tag_we; stall_n; mem_* memory interface.
// Macro CACHE_ARB_ROUND_ROBIN_EN: round-robin grant instead of fixed.
module cache_arbiter_n
    import cache_arb_pkg::*;
#(
    parameter int NUM_PORTS       = DEF_NUM_PORTS,
    parameter int WORDS_PER_BLOCK = DEF_WORDS_PER_BLOCK,
    parameter int ADDR_W          = DEF_ADDR_W,
    parameter int DATA_W          = DEF_DATA_W
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_PORTS-1:0]        miss_req,
    input  logic [NUM_PORTS*ADDR_W-1:0] miss_addr,
    input  logic                        wr_req,
    input  logic [ADDR_W-1:0]           wr_addr,
    input  logic [DATA_W-1:0]           wr_data,
    output logic                        wr_ack,
    output logic [DATA_W-1:0]           fill_data,
    output logic [ADDR_W-1:0]           fill_addr,
    output logic [NUM_PORTS-1:0]        fill_data_we,
    output logic [NUM_PORTS-1:0]        fill_tag_we,
    output logic                        stall_n,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_wdata,
    output logic                        mem_enable,
    output logic                        mem_wr,
    input  logic [DATA_W-1:0]           mem_rdata,
    input  logic                        mem_data_valid
);

    localparam int CW = $clog2(WORDS_PER_BLOCK) + 1;
    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    // Block offset bits: log2(W) word bits plus the byte-in-word bit.
    localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'((1 << CW) - 1);
    localparam logic [CW-1:0] LAST   = CW'(WORDS_PER_BLOCK - 1);
    localparam logic [CW-1:0] NWORDS = CW'(WORDS_PER_BLOCK);
    localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(WORD_STRIDE);

    arb_state_e state_q, state_d;

    logic [CW-1:0]        issue_q, issue_d;
    logic [CW-1:0]        recv_q, recv_d;
    logic [NUM_PORTS-1:0] grant_q, grant_d;
    logic [ADDR_W-1:0]    base_q, base_d;
    logic [ADDR_W-1:0]    wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]    wr_data_q, wr_data_d;

    logic [NUM_PORTS-1:0] gnt;
    logic [ADDR_W-1:0]    sel_addr;
    logic                 last_word;

`ifdef CACHE_ARB_ROUND_ROBIN_EN
    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW-1:0] gnt_idx;

    rr_arbiter #(.N(NUM_PORTS), .PW(PW)) u_arb (
        .req_i (miss_req),
        .ptr_i (ptr_q),
        .gnt_o (gnt)
    );

    always_comb begin
        gnt_idx = '0;
        for (int j = 0; j < NUM_PORTS; j++) begin
            if (gnt[j]) gnt_idx = PW'(j);
        end
    end
`else
    rr_arbiter #(.N(NUM_PORTS), .PW(PW)) u_arb (
        .req_i (miss_req),
        .gnt_o (gnt)
    );
`endif

    always_comb begin
        sel_addr = '0;
        for (int j = 0; j < NUM_PORTS; j++) begin
            if (gnt[j]) sel_addr = miss_addr[j*ADDR_W +: ADDR_W];
        end
    end

    assign last_word = (state_q == ST_FILL) && mem_data_valid &&
                       (recv_q == LAST);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic; writes take precedence over fills.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (wr_req)         state_d = ST_WRITE;
                else if (|miss_req) state_d = ST_FILL;
            end
            ST_WRITE: state_d = ST_IDLE;
            ST_FILL:  if (last_word) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Datapath next-state.
    always_comb begin
        issue_d   = issue_q;
        recv_d    = recv_q;
        grant_d   = grant_q;
        base_d    = base_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
`ifdef CACHE_ARB_ROUND_ROBIN_EN
        ptr_d     = ptr_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (wr_req) begin
                    wr_addr_d = wr_addr;
                    wr_data_d = wr_data;
                end else if (|miss_req) begin
                    grant_d = gnt;
                    base_d  = sel_addr & ~LOW_MASK;
                    issue_d = '0;
                    recv_d  = '0;
`ifdef CACHE_ARB_ROUND_ROBIN_EN
                    ptr_d   = gnt_idx;
`endif
                end
            end
            ST_FILL: begin
                if (issue_q < NWORDS) issue_d = issue_q + CW'(1);
                if (mem_data_valid)   recv_d  = recv_q + CW'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issue_q   <= '0;
            recv_q    <= '0;
            grant_q   <= '0;
            base_q    <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
`ifdef CACHE_ARB_ROUND_ROBIN_EN
            ptr_q     <= PW'(NUM_PORTS - 1);
`endif
        end else begin
            issue_q   <= issue_d;
            recv_q    <= recv_d;
            grant_q   <= grant_d;
            base_q    <= base_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
`ifdef CACHE_ARB_ROUND_ROBIN_EN
            ptr_q     <= ptr_d;
`endif
        end
    end

    // Output logic.
    always_comb begin
        wr_ack       = 1'b0;
        fill_data    = '0;
        fill_addr    = '0;
        fill_data_we = '0;
        fill_tag_we  = '0;
        mem_addr     = '0;
        mem_wdata    = '0;
        mem_enable   = 1'b0;
        mem_wr       = 1'b0;
        unique case (state_q)
            ST_WRITE: begin
                mem_enable = 1'b1;
                mem_wr     = 1'b1;
                mem_addr   = wr_addr_q;
                mem_wdata  = wr_data_q;
                wr_ack     = 1'b1;
            end
            ST_FILL: begin
                if (issue_q < NWORDS) begin
                    mem_enable = 1'b1;
                    mem_addr   = base_q + STRIDE * ADDR_W'(issue_q);
                end
                if (mem_data_valid) begin
                    fill_data    = mem_rdata;
                    fill_addr    = base_q + STRIDE * ADDR_W'(recv_q);
                    fill_data_we = grant_q;
                end
                if (last_word) fill_tag_we = grant_q;
            end
            default: ;
        endcase
    end

    assign stall_n = ~((state_q != ST_IDLE) | (|miss_req));

endmodule
